// File: rtl/pic_pkg.sv
// Shared codes, states and helpers for the 8259A control core.
// Imported by the sequencer and its priority resolver.
package pic_pkg;

  localparam logic [2:0] WF_ICW1 = 3'd0;
  localparam logic [2:0] WF_ICW2 = 3'd1;
  localparam logic [2:0] WF_ICW3 = 3'd2;
  localparam logic [2:0] WF_ICW4 = 3'd3;
  localparam logic [2:0] WF_OCW1 = 3'd4;
  localparam logic [2:0] WF_OCW2 = 3'd5;
  localparam logic [2:0] WF_OCW3 = 3'd6;

  localparam logic [2:0] RF_IRR = 3'd0;
  localparam logic [2:0] RF_ISR = 3'd1;
  localparam logic [2:0] RF_IMR = 3'd2;

  localparam logic [2:0] OCW2_NS_EOI = 3'b001;
  localparam logic [2:0] OCW2_SP_EOI = 3'b011;

  typedef enum logic [2:0] {
    UNINIT,
    W_ICW2,
    W_ICW3,
    W_ICW4,
    READY,
    ACK1,
    ACK2
  } pic_state_t;

  // {found, index} of the lowest set bit; IR0 has top priority.
  function automatic logic [3:0] first_set(input logic [7:0] v);
    logic [3:0] r;
    r = 4'h0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/pic_prio_resolver.sv
// Fixed-priority resolver: request candidate and highest in-service level.
// Purely combinational so rotation modes can wrap it later.
module pic_prio_resolver
  import pic_pkg::*;
(
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic [7:0] isr,
  output logic       cand_valid,
  output logic [2:0] cand_idx,
  output logic       isr_valid,
  output logic [2:0] isr_idx
);

  assign {cand_valid, cand_idx} = first_set(irr & ~imr);
  assign {isr_valid, isr_idx}   = first_set(isr);

endmodule

// File: rtl/pic_int_sequencer.sv
// 8259A control core: ICW/OCW sequencing, IRR/IMR/ISR and 8086 INTA.
// Define PIC_AUTO_EOI_EN to honour ICW4 AEOI.
module pic_int_sequencer
  import pic_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       W_STB,
  input  logic [7:0] W_DATA,
  input  logic [2:0] W_FLAG,
  input  logic [2:0] R_FLAG,
  input  logic [7:0] IR,
  input  logic       INTA_n,
  output logic       INT,
  output logic [7:0] ICW2_O,
  output logic [7:0] ICW3_O,
  output logic       SNGL,
  output logic [7:0] ACK_SEL,
  output logic [7:0] VEC_DATA,
  output logic       VEC_VALID,
  output logic [7:0] RD_DATA
);

  pic_state_t state, state_n;

  logic       ltim, sngl, ic4, aeoi;
  logic [7:0] icw2, icw3, imr, isr, irr;
  logic [7:0] ir_s1, ir_s2, ir_prev;
  logic       inta_s1, inta_s2, inta_prev;
  logic [2:0] lvl;
  logic       spur;
  logic       int_q;
  logic [7:0] ack_sel;
  logic       vec_valid;

  logic       is_icw1, ocw_ok;
  logic       inta_fall, inta_rise;
  logic [3:0] isr_top;
  logic [7:0] eoi_mask, isr_eoi;
  logic       cand_valid, isr_valid, cand_ok;
  logic [2:0] cand_idx, isr_idx, new_lvl;
  logic       enter_ack1, enter_ack2, exit_ack2;
  logic [7:0] irr_n, isr_n;
  logic       int_n;

  assign is_icw1   = W_STB && (W_FLAG == WF_ICW1);
  assign ocw_ok    = (state == READY) || (state == ACK1) ||
                     (state == ACK2);
  assign inta_fall = inta_prev & ~inta_s2;
  assign inta_rise = ~inta_prev & inta_s2;

  // EOI lands before the acknowledge resolves its level.
  assign isr_top = first_set(isr);

  always_comb begin
    eoi_mask = 8'h00;
    if (ocw_ok && W_STB && (W_FLAG == WF_OCW2)) begin
      case (W_DATA[7:5])
        OCW2_NS_EOI: if (isr_top[3]) eoi_mask = 8'b1 << isr_top[2:0];
        OCW2_SP_EOI: eoi_mask = 8'b1 << W_DATA[2:0];
        default:     eoi_mask = 8'h00;
      endcase
    end
  end

  assign isr_eoi = isr & ~eoi_mask;

  pic_prio_resolver u_prio (
    .irr        (irr),
    .imr        (imr),
    .isr        (isr_eoi),
    .cand_valid (cand_valid),
    .cand_idx   (cand_idx),
    .isr_valid  (isr_valid),
    .isr_idx    (isr_idx)
  );

  assign cand_ok = cand_valid && (!isr_valid || (cand_idx < isr_idx));
  assign new_lvl = cand_ok ? cand_idx : 3'd7;

  always_comb begin
    state_n = state;
    if (is_icw1) begin
      state_n = W_ICW2;
    end else begin
      unique case (state)
        W_ICW2: if (W_STB && W_FLAG == WF_ICW2)
                  state_n = !sngl ? W_ICW3 : (ic4 ? W_ICW4 : READY);
        W_ICW3: if (W_STB && W_FLAG == WF_ICW3)
                  state_n = ic4 ? W_ICW4 : READY;
        W_ICW4: if (W_STB && W_FLAG == WF_ICW4)
                  state_n = READY;
        READY:  if (inta_fall) state_n = ACK1;
        ACK1:   if (inta_fall) state_n = ACK2;
        ACK2:   if (inta_rise) state_n = READY;
        default: state_n = state;
      endcase
    end
  end

  assign enter_ack1 = (state == READY) && (state_n == ACK1);
  assign enter_ack2 = (state == ACK1) && (state_n == ACK2);
  assign exit_ack2  = (state == ACK2) && (state_n == READY);

  always_comb begin
    irr_n = ltim ? ir_s2 : ((irr | (ir_s2 & ~ir_prev)) & ir_s2);
    if (enter_ack1 && cand_ok && !ltim)
      irr_n = irr_n & ~(8'b1 << new_lvl);
    isr_n = isr_eoi;
    if (enter_ack1 && cand_ok)
      isr_n = isr_n | (8'b1 << new_lvl);
    if (exit_ack2 && aeoi && !spur)
      isr_n = isr_n & ~(8'b1 << lvl);
    int_n = (state == READY) && (state_n == READY) && cand_ok;
  end

`ifdef PIC_AUTO_EOI_EN
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      aeoi <= 1'b0;
    end else if (state == W_ICW4 && W_STB && W_FLAG == WF_ICW4
                 && !is_icw1) begin
      aeoi <= W_DATA[1];
    end
  end
`else
  assign aeoi = 1'b0;
`endif

  // INTA idles high, so its synchronizer resets high too.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state     <= UNINIT;
      ltim      <= 1'b0;
      sngl      <= 1'b0;
      ic4       <= 1'b0;
      icw2      <= 8'h00;
      icw3      <= 8'h00;
      imr       <= 8'h00;
      isr       <= 8'h00;
      irr       <= 8'h00;
      ir_s1     <= 8'h00;
      ir_s2     <= 8'h00;
      ir_prev   <= 8'h00;
      inta_s1   <= 1'b1;
      inta_s2   <= 1'b1;
      inta_prev <= 1'b1;
      lvl       <= 3'd0;
      spur      <= 1'b0;
      int_q     <= 1'b0;
      ack_sel   <= 8'h00;
      vec_valid <= 1'b0;
    end else begin
      state     <= state_n;
      ir_s1     <= IR;
      ir_s2     <= ir_s1;
      inta_s1   <= INTA_n;
      inta_s2   <= inta_s1;
      inta_prev <= inta_s2;
      if (is_icw1) begin
        ltim      <= W_DATA[3];
        sngl      <= W_DATA[1];
        ic4       <= W_DATA[0];
        imr       <= 8'h00;
        isr       <= 8'h00;
        irr       <= 8'h00;
        ir_prev   <= 8'h00;
        int_q     <= 1'b0;
        ack_sel   <= 8'h00;
        vec_valid <= 1'b0;
      end else begin
        ir_prev <= ir_s2;
        irr     <= irr_n;
        isr     <= isr_n;
        int_q   <= int_n;
        if (state == W_ICW2 && W_STB && W_FLAG == WF_ICW2)
          icw2 <= W_DATA;
        if (state == W_ICW3 && W_STB && W_FLAG == WF_ICW3)
          icw3 <= W_DATA;
        if (ocw_ok && W_STB && W_FLAG == WF_OCW1)
          imr <= W_DATA;
        if (enter_ack1) begin
          lvl     <= new_lvl;
          spur    <= !cand_ok;
          ack_sel <= 8'b1 << new_lvl;
        end
        if (enter_ack2)
          vec_valid <= 1'b1;
        if (exit_ack2) begin
          vec_valid <= 1'b0;
          ack_sel   <= 8'h00;
        end
      end
    end
  end

  always_comb begin
    case (R_FLAG)
      RF_IRR:  RD_DATA = irr;
      RF_ISR:  RD_DATA = isr;
      RF_IMR:  RD_DATA = imr;
      default: RD_DATA = 8'h00;
    endcase
  end

  assign INT       = int_q;
  assign ICW2_O    = icw2;
  assign ICW3_O    = icw3;
  assign SNGL      = sngl;
  assign ACK_SEL   = ack_sel;
  assign VEC_DATA  = {icw2[7:3], lvl};
  assign VEC_VALID = vec_valid;

endmodule

// File: tb/tb_pic_int_sequencer.sv
// Scoreboard bench for pic_int_sequencer with a priority model.
// Vectors are queued at INTA issue and checked when VEC_VALID rises.
module tb_pic_int_sequencer;

  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic       W_STB = 1'b0;
  logic [7:0] W_DATA = 8'h00;
  logic [2:0] W_FLAG = 3'd7;
  logic [2:0] R_FLAG = 3'd0;
  logic [7:0] IR = 8'h00;
  logic       INTA_n = 1'b1;
  logic       INT;
  logic [7:0] ICW2_O, ICW3_O, ACK_SEL, VEC_DATA, RD_DATA;
  logic       SNGL, VEC_VALID;

  pic_int_sequencer dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .W_STB     (W_STB),
    .W_DATA    (W_DATA),
    .W_FLAG    (W_FLAG),
    .R_FLAG    (R_FLAG),
    .IR        (IR),
    .INTA_n    (INTA_n),
    .INT       (INT),
    .ICW2_O    (ICW2_O),
    .ICW3_O    (ICW3_O),
    .SNGL      (SNGL),
    .ACK_SEL   (ACK_SEL),
    .VEC_DATA  (VEC_DATA),
    .VEC_VALID (VEC_VALID),
    .RD_DATA   (RD_DATA)
  );

  always #5 CLK = ~CLK;

`ifdef PIC_AUTO_EOI_EN
  localparam bit AEOI = 1'b1;
`else
  localparam bit AEOI = 1'b0;
`endif

  typedef struct {
    logic [7:0] vec;
    logic [7:0] ack;
    bit         spur;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  logic [7:0] m_irr = 8'h00;
  logic [7:0] m_imr = 8'h00;
  logic [7:0] m_isr = 8'h00;
  logic [7:0] m_ir = 8'h00;
  logic [7:0] m_icw2 = 8'h00;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Walk from IR0 down: an in-service level blocks itself and below.
  function automatic int exp_level();
    for (int i = 0; i < 8; i++) begin
      if (m_isr[i]) return -1;
      if (m_irr[i] && !m_imr[i]) return i;
    end
    return -1;
  endfunction

  logic vv_d = 1'b0;
  always @(negedge CLK) begin
    exp_t e;
    if (VEC_VALID && !vv_d) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL vec_unexpected actual=%h expected=none", VEC_DATA);
      end else begin
        e = sbq.pop_front();
        chk("vec_data", VEC_DATA, e.vec);
        if (!e.spur) chk("ack_sel", ACK_SEL, e.ack);
      end
    end
    vv_d <= VEC_VALID;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wr(input logic [2:0] f, input logic [7:0] d);
    @(negedge CLK);
    W_STB = 1'b1;
    W_FLAG = f;
    W_DATA = d;
    @(negedge CLK);
    W_STB = 1'b0;
    W_FLAG = 3'd7;
  endtask

  task automatic rd(input logic [2:0] f, input logic [7:0] exp,
                    input string nm);
    @(negedge CLK);
    R_FLAG = f;
    #1 chk(nm, RD_DATA, exp);
  endtask

  task automatic ir_set(input logic [7:0] v);
    @(negedge CLK);
    IR = v;
    m_irr = (m_irr | (v & ~m_ir)) & v;
    m_ir = v;
  endtask

  task automatic chk_int(input string nm);
    @(negedge CLK);
    chk(nm, {7'b0, INT}, {7'b0, exp_level() >= 0});
  endtask

  task automatic ns_eoi();
    wr(3'd5, 8'h20);
    for (int i = 0; i < 8; i++) begin
      if (m_isr[i]) begin
        m_isr[i] = 1'b0;
        break;
      end
    end
  endtask

  task automatic push_exp(output int lv, output bit sp);
    exp_t e;
    int l;
    logic [2:0] l3;
    l = exp_level();
    sp = (l < 0);
    lv = sp ? 7 : l;
    l3 = 3'(lv);
    e.vec = {m_icw2[7:3], l3};
    e.ack = 8'h01 << lv;
    e.spur = sp;
    sbq.push_back(e);
  endtask

  task automatic inta_cycle();
    int lv;
    bit sp;
    push_exp(lv, sp);
    INTA_n = 1'b0; cyc(4);
    INTA_n = 1'b1; cyc(4);
    INTA_n = 1'b0; cyc(4);
    INTA_n = 1'b1; cyc(5);
    if (!sp) begin
      m_isr[lv] = 1'b1;
      m_irr[lv] = 1'b0;
      if (AEOI) m_isr[lv] = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int lv;
    bit sp;
    logic [7:0] isr_save;
    cyc(3);
    chk("rst_int", {7'b0, INT}, 8'h00);
    chk("rst_ack_sel", ACK_SEL, 8'h00);
    chk("rst_vec_valid", {7'b0, VEC_VALID}, 8'h00);
    chk("rst_vec_data", VEC_DATA, 8'h00);
    chk("rst_icw2", ICW2_O, 8'h00);
    chk("rst_sngl", {7'b0, SNGL}, 8'h00);
    RST_n = 1'b1;
    cyc(2);
    rd(3'd0, 8'h00, "rst_irr");
    rd(3'd1, 8'h00, "rst_isr");
    rd(3'd2, 8'h00, "rst_imr");

    wr(3'd0, 8'h13);
    wr(3'd1, 8'h40);
    m_icw2 = 8'h40;
    wr(3'd4, 8'hFF);
    rd(3'd2, 8'h00, "ocw_ignored_in_init");
    wr(3'd3, AEOI ? 8'h03 : 8'h01);
    wr(3'd4, 8'h5A);
    rd(3'd2, 8'h5A, "imr_ready");
    chk("icw2_o", ICW2_O, 8'h40);
    chk("sngl", {7'b0, SNGL}, 8'h01);
    chk("icw3_skipped", ICW3_O, 8'h00);
    wr(3'd4, 8'h00);
    m_imr = 8'h00;

    ir_set(8'h08);
    cyc(6);
    chk("int_ir3", {7'b0, INT}, 8'h01);
    inta_cycle();
    rd(3'd1, m_isr, "isr_ir3");
    ir_set(8'h00);
    cyc(4);

    ir_set(8'h20);
    cyc(6);
    chk_int("int_ir5_blocked");
    ns_eoi();
    cyc(3);
    chk_int("int_ir5_after_eoi");
    chk("int_ir5_high", {7'b0, INT}, 8'h01);
    inta_cycle();
    ir_set(8'h00);
    ns_eoi();
    rd(3'd1, m_isr, "isr_after_eoi");

    wr(3'd4, 8'h04);
    m_imr = 8'h04;
    ir_set(8'h44);
    cyc(6);
    chk_int("int_ir6");
    inta_cycle();
    ir_set(8'h00);
    ns_eoi();
    wr(3'd4, 8'h00);
    m_imr = 8'h00;
    cyc(4);

    chk_int("int_none");
    isr_save = m_isr;
    inta_cycle();
    rd(3'd1, isr_save, "isr_spurious");

    for (int it = 0; it < 25; it++) begin
      logic [7:0] im, iv;
      logic [2:0] sl;
      im = 8'($urandom);
      iv = 8'($urandom);
      wr(3'd4, im);
      m_imr = im;
      ir_set(iv);
      cyc(6);
      rd(3'd0, m_irr, "rnd_irr");
      chk_int("rnd_int");
      inta_cycle();
      rd(3'd1, m_isr, "rnd_isr");
      ir_set(8'h00);
      cyc(4);
      case ($urandom_range(0, 2))
        0: ns_eoi();
        1: begin
          sl = 3'($urandom);
          wr(3'd5, {3'b011, 2'b00, sl});
          m_isr[sl] = 1'b0;
        end
        default: ;
      endcase
    end

    wr(3'd4, 8'h00);
    m_imr = 8'h00;
    wr(3'd5, 8'h20);
    wr(3'd5, 8'h20);
    for (int i = 0; i < 8; i++) wr(3'd5, {5'b01100, 3'(i)});
    m_isr = 8'h00;
    ir_set(8'h02);
    cyc(6);
    push_exp(lv, sp);
    INTA_n = 1'b0; cyc(4);
    INTA_n = 1'b1; cyc(4);
    INTA_n = 1'b0; cyc(4);
    chk("vec_valid_ack2", {7'b0, VEC_VALID}, 8'h01);
    #2 RST_n = 1'b0;
    #1;
    chk("abort_vec_valid", {7'b0, VEC_VALID}, 8'h00);
    chk("abort_ack_sel", ACK_SEL, 8'h00);
    chk("abort_int", {7'b0, INT}, 8'h00);
    chk("abort_vec_data", VEC_DATA, 8'h00);
    INTA_n = 1'b1;
    IR = 8'h00;
    cyc(3);
    RST_n = 1'b1;
    cyc(2);
    wr(3'd4, 8'hFF);
    rd(3'd2, 8'h00, "abort_uninit_imr");
    rd(3'd1, 8'h00, "abort_isr");
    cyc(2);
    chk("sb_drained", 8'(sbq.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pic_int_sequencer.md
# pic_int_sequencer

Control core of the 8259A model. Sequences the ICW1–ICW4 initialization handshake and decodes OCW1–OCW3. Holds IRR/IMR/ISR, resolves fixed priority, drives `INT`, and steps the two-pulse 8086 INTA cycle. It sits between the read/write decode logic and the cascade comparator, supplying ICW2/ICW3/SNGL, the one-hot acknowledged level and the vector byte for the internal bus.

## Interface
- No parameters; the width is fixed at 8 IR lines.
- `CLK  in  1  system clock; all state changes on the rising edge`
- `RST_n  in  1  asynchronous active-low reset`
- `W_STB  in  1  one-cycle strobe; W_DATA/W_FLAG valid`
- `W_DATA  in  8  ICW/OCW byte from the write decode`
- `W_FLAG  in  3  0=ICW1 1=ICW2 2=ICW3 3=ICW4 4=OCW1 5=OCW2 6=OCW3 7=ignored`
- `R_FLAG  in  3  read select: 0=IRR 1=ISR 2=IMR, others return 8'h00`
- `IR  in  8  asynchronous interrupt request pins`
- `INTA_n  in  1  asynchronous acknowledge pin, active low`
- `INT  out  1  interrupt request to CPU`
- `ICW2_O  out  8  stored ICW2 (vector base)`
- `ICW3_O  out  8  stored ICW3`
- `SNGL  out  1  ICW1[1]`
- `ACK_SEL  out  8  one-hot level under acknowledge, 0 otherwise`
- `VEC_DATA  out  8  {ICW2[7:3], level}`
- `VEC_VALID  out  1  VEC_DATA is to be driven on the internal bus`
- `RD_DATA  out  8  register selected by R_FLAG, combinational`

## Operation
- States: `UNINIT`, `W_ICW2`, `W_ICW3`, `W_ICW4`, `READY`, `ACK1`, `ACK2`.
- ICW1 strobe in any state:
  - Latches LTIM=ICW1[3], SNGL=ICW1[1], IC4=ICW1[0].
  - Clears IMR, ISR, IRR and the edge history.
  - Goes to `W_ICW2`. Overrides all other activity, including mid-INTA.
- `W_ICW2` + ICW2 → `W_ICW3` if SNGL=0; else `W_ICW4` if IC4=1; else `READY`.
- `W_ICW3` + ICW3 → `W_ICW4` if IC4=1, else `READY`.
- `W_ICW4` + ICW4 → `READY`; latches AEOI=ICW4[1].
- Wrong-flag strobes during init are ignored. OCWs outside `READY`/`ACK*` are ignored.
- OCW1 sets IMR = W_DATA.
- OCW2 decode on W_DATA[7:5]:
  - `001` clears the highest-priority ISR bit (non-specific EOI).
  - `011` clears ISR[W_DATA[2:0]] (specific EOI).
  - All other codes are no-ops.
- OCW3 has no state effect; reads are selected by R_FLAG.
- IR passes through a 2-flop synchronizer.
  - Edge mode (LTIM=0): IRR bit sets on a synced 0→1 edge and clears when the synced IR is low.
  - Level mode: IRR bit equals the synced IR.
- Priority is fixed, IR0 highest. The candidate is the lowest index of IRR & ~IMR.
- `INT` is asserted in `READY` when a candidate exists and its index is lower than every set ISR index.
- INTA_n is synchronized by 2 flops. A falling edge is detected on the synced signal.
- `READY`, INTA fall → `ACK1`:
  - Freezes the candidate level L; if none, L=7 (spurious, ISR untouched).
  - Sets ISR[L], clears IRR[L] (edge mode), drives `ACK_SEL`=1<<L, clears `INT`.
- `ACK1`, INTA fall → `ACK2`: `VEC_VALID`=1, `VEC_DATA`={ICW2[7:3],L}.
- `ACK2`, synced INTA rise → `READY`.
  - `VEC_VALID` and `ACK_SEL` drop.
  - AEOI clears ISR[L] on this transition.

## Timing
- Reset: state `UNINIT`, all registers 0, `INT`=0, `ACK_SEL`=0, `VEC_VALID`=0, `VEC_DATA`=0.
- Register writes take effect the cycle after W_STB.
- IR to IRR: 3 cycles. IRR to `INT`: 1 further cycle (registered).
- INTA_n edge to state change: 3 cycles. INTA low pulses must be at least 3 CLK wide.
- An OCW2 EOI and an INTA fall in the same cycle: the EOI is applied first, then priority is resolved.
- Reset mid-INTA aborts immediately. All outputs return to reset values.

## Configuration
- `PIC_AUTO_EOI_EN` defined: ICW4[1] is honoured and ISR is cleared automatically at the end of `ACK2`.
- Undefined: the AEOI register and its logic are removed, ICW4[1] is ignored, and ISR is cleared only by OCW2.

## Structure
- Shared package `pic_pkg`: W_FLAG and R_FLAG code constants, state enum, OCW2 opcode constants.
- Sub-module `pic_prio_resolver`: combinational. Takes IRR, IMR and ISR; returns candidate valid, candidate index and highest-ISR index. It is reused later for rotation modes.

## Test plan
- Single mode, ICW1=8'h13, ICW2=8'h40, ICW4=8'h01 → state `READY` after the third strobe, with ICW3 skipped.
- IMR=0, IR3 pulse (edge mode) → `INT`=1, two INTA pulses → `ACK_SEL`=8'h08, `VEC_DATA`=8'h43, ISR=8'h08.
- With ISR=8'h08, raise IR5 → `INT` stays 0. OCW2=8'h20 → ISR=0 and `INT` rises for IR5.
- IR2 and IR6 together, IMR=8'h04 → vector level 6, `ACK_SEL`=8'h40.
- INTA with no request → `VEC_DATA`={ICW2[7:3],3'b111}, ISR unchanged.
- Assert RST_n low during `ACK2` → `VEC_VALID`=0 and state `UNINIT` without any clock.
- With `PIC_AUTO_EOI_EN` defined and ICW4=8'h03, an IR1 acknowledge cycle leaves ISR=0 after INTA rises.
